// File: rtl/serial_frame_ctrl.sv
// Serial frame sequencer: start bit, PORT_BITS port number, DATA_BITS payload (MSB first),
// then holds the frame for a valid/ready consumer. Define SERIAL_FRAME_PARITY_EN for an even-parity bit.
`timescale 1ns/1ps
module serial_frame_ctrl #(
  parameter int PORT_BITS = 2,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clkEn,
  input  logic                 serIn,
  input  logic                 ready,
  output logic [PORT_BITS-1:0] portNum,
  output logic [DATA_BITS-1:0] dataOut,
  output logic                 dataValid,
  output logic                 busy,
  output logic                 done,
  output logic                 parityErr
);

  localparam int PCW = $clog2(PORT_BITS + 1);
  localparam int DCW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    PORT,
    DATA,
`ifdef SERIAL_FRAME_PARITY_EN
    PAR,
`endif
    HOLD
  } state_t;

  state_t         state;
  logic [PCW-1:0] pcnt;
  logic [DCW-1:0] dcnt;

`ifndef SERIAL_FRAME_PARITY_EN
  assign parityErr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      portNum   <= '0;
      dataOut   <= '0;
      pcnt      <= '0;
      dcnt      <= '0;
      dataValid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
      parityErr <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (clkEn && !serIn) begin
            state <= PORT;
            pcnt  <= '0;
            dcnt  <= '0;
            busy  <= 1'b1;
          end
        end
        PORT: begin
          if (clkEn) begin
            // Cast keeps the low bits of {portNum, serIn}; also covers PORT_BITS == 1.
            portNum <= PORT_BITS'({portNum, serIn});
            pcnt    <= pcnt + PCW'(1);
            if (pcnt == PCW'(PORT_BITS - 1))
              state <= DATA;
          end
        end
        DATA: begin
          if (clkEn) begin
            dataOut <= DATA_BITS'({dataOut, serIn});
            dcnt    <= dcnt + DCW'(1);
            if (dcnt == DCW'(DATA_BITS - 1)) begin
`ifdef SERIAL_FRAME_PARITY_EN
              state <= PAR;
`else
              state     <= HOLD;
              busy      <= 1'b0;
              dataValid <= 1'b1;
`endif
            end
          end
        end
`ifdef SERIAL_FRAME_PARITY_EN
        PAR: begin
          if (clkEn) begin
            // Even parity: the received bit must equal the XOR of all captured bits.
            parityErr <= serIn != (^{portNum, dataOut});
            state     <= HOLD;
            busy      <= 1'b0;
            dataValid <= 1'b1;
          end
        end
`endif
        HOLD: begin
          if (ready) begin
            state     <= IDLE;
            dataValid <= 1'b0;
            done      <= 1'b1;
`ifdef SERIAL_FRAME_PARITY_EN
            parityErr <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Scoreboard bench for serial_frame_ctrl: stimulus pushes expected frames, a negedge monitor pops and checks.
`timescale 1ns/1ps
module tb_serial_frame_ctrl;

  localparam int PB = 2;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          clkEn;
  logic          serIn;
  logic          ready;
  logic [PB-1:0] portNum;
  logic [DB-1:0] dataOut;
  logic          dataValid;
  logic          busy;
  logic          done;
  logic          parityErr;

  serial_frame_ctrl #(.PORT_BITS(PB), .DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst), .clkEn(clkEn), .serIn(serIn), .ready(ready),
    .portNum(portNum), .dataOut(dataOut), .dataValid(dataValid),
    .busy(busy), .done(done), .parityErr(parityErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PB-1:0] port;
    logic [DB-1:0] data;
    logic          perr;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   vectors = 0;
  int   fails   = 0;

`ifdef SERIAL_FRAME_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " portNum"}, 64'(portNum), 0);
    chk({tag, " dataOut"}, 64'(dataOut), 0);
    chk({tag, " valid/busy/done/perr"}, 64'({dataValid, busy, done, parityErr}), 0);
  endtask

  // kind: 0 = middle bit, 1 = start bit, 2 = final bit of the frame.
  task automatic send_bit(input logic b, input int gmin, input int gmax, input int kind);
    int gap;
    gap = $urandom_range(gmax, gmin);
    repeat (gap) begin
      clkEn = 1'b0;
      serIn = 1'($urandom);
      ready = 1'($urandom);
      @(posedge clk); #1;
      if (kind != 1) chk("hold busy/valid", 64'({busy, dataValid}), 64'b10);
    end
    if (kind == 2) chk("pre-last busy/valid", 64'({busy, dataValid}), 64'b10);
    clkEn = 1'b1;
    serIn = b;
    ready = 1'($urandom);
    @(posedge clk); #1;
    clkEn = 1'b0;
    serIn = 1'b1;
    ready = 1'b0;
    if (kind == 1) chk("start busy/valid", 64'({busy, dataValid}), 64'b10);
    if (kind == 2) chk("last busy/valid", 64'({busy, dataValid}), 64'b01);
  endtask

  task automatic send_frame(input logic [PB-1:0] port, input logic [DB-1:0] data,
                            input logic pbit, input int gmin, input int gmax);
    exp_t e;
    e.port = port;
    e.data = data;
    e.perr = PAR_EN && ((($countones(port) + $countones(data) + int'(pbit)) % 2) != 0);
    q.push_back(e);
    send_bit(1'b0, gmin, gmax, 1);
    for (int i = PB - 1; i >= 0; i--) send_bit(port[i], gmin, gmax, 0);
    for (int i = DB - 1; i >= 0; i--)
      send_bit(data[i], gmin, gmax, (i == 0 && !PAR_EN) ? 2 : 0);
    if (PAR_EN) send_bit(pbit, gmin, gmax, 2);
  endtask

  // Stall with ready low, then accept while offering a start bit that must be ignored.
  task automatic accept(input int hold);
    repeat (hold) begin
      ready = 1'b0;
      clkEn = 1'($urandom);
      serIn = 1'($urandom);
      @(posedge clk); #1;
    end
    ready = 1'b1;
    clkEn = 1'b1;
    serIn = 1'b0;
    @(posedge clk); #1;
    ready = 1'b0;
    clkEn = 1'b0;
    serIn = 1'b1;
    chk("accept done/valid/busy", 64'({done, dataValid, busy}), 64'b100);
  endtask

  // Monitor: done follows an accepted edge; frame contents checked while dataValid is high.
  bit prev_valid = 1'b0;
  bit acc        = 1'b0;
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      chk_zero("mon reset");
      prev_valid = 1'b0;
      acc        = 1'b0;
    end else begin
      chk("mon done", 64'(done), 64'(acc));
      if (acc) chk("mon valid drop", 64'(dataValid), 0);
      if (dataValid) begin
        if (!prev_valid) begin
          if (q.size() == 0) begin
            vectors++;
            fails++;
            $display("FAIL mon unexpected frame: got valid=1 expected no frame at %0t", $time);
          end else cur = q.pop_front();
        end
        chk("mon portNum", 64'(portNum), 64'(cur.port));
        chk("mon dataOut", 64'(dataOut), 64'(cur.data));
        chk("mon parityErr", 64'(parityErr), 64'(cur.perr));
        chk("mon busy in hold", 64'(busy), 0);
      end
      acc        = dataValid && ready;
      prev_valid = dataValid;
    end
  end

  initial begin
    rst   = 1'b0;
    clkEn = 1'b0;
    serIn = 1'b1;
    ready = 1'b0;
    #1 chk_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Basic frame, strobe held high, then a 5-cycle stall before acceptance.
    send_frame(2'b10, 8'hA3, 1'b1, 0, 0);
    accept(5);
    if (PAR_EN) begin
      send_frame(2'b10, 8'hA3, 1'b0, 0, 0);
      accept(1);
    end

    // Same frame with the strobe only every 4th cycle.
    send_frame(2'b10, 8'hA3, 1'b1, 3, 3);
    accept(0);

    // Idle line: strobes with serIn high never start a frame.
    for (int i = 0; i < 20; i++) begin
      clkEn = 1'b1;
      serIn = 1'b1;
      ready = 1'($urandom);
      @(posedge clk); #1;
      chk("idle busy/valid", 64'({busy, dataValid}), 0);
    end
    ready = 1'b0;

    // Asynchronous reset five samples into a frame.
    send_bit(1'b0, 0, 0, 1);
    send_bit(1'b1, 0, 0, 0);
    send_bit(1'b0, 0, 0, 0);
    send_bit(1'b1, 0, 0, 0);
    send_bit(1'b1, 0, 0, 0);
    #2 rst = 1'b0;
    #1 chk_zero("async reset");
    @(posedge clk); #1 rst = 1'b1;
    send_frame(2'b01, 8'h5C, 1'b1, 0, 2);
    accept(2);

    // Randomized frames.
    for (int n = 0; n < 30; n++) begin
      send_frame(PB'($urandom), DB'($urandom), 1'($urandom), 0, $urandom_range(3, 0));
      accept($urandom_range(3, 0));
    end

    repeat (3) @(posedge clk);
    #1 chk("scoreboard drained", 64'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
